// File: rtl/amt_recovery_pkg.sv
// Shared types and constants for AMT-to-RMT recovery.
// Optional feature macro: AMT_RECOVER_PIPE_EN (registers AMT data one stage before the RMT).
package amt_recovery_pkg;

  // Recovery walk states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } recoverState_t;

  // Entries restored per cycle (RMT write port count)
  localparam int RECOVER_WIDTH = 4;

  // Packet layout {logical index, physical tag}; shared with the AMT and RMT
  localparam int PKT_TAG_LSB = 0;

  function automatic int pktIndexLsb(input int sizePhysicalLog);
    return PKT_TAG_LSB + sizePhysicalLog;
  endfunction

  // Number of groups needed to cover every logical register
  function automatic int groupCount(input int sizeRmt);
    return (sizeRmt + RECOVER_WIDTH - 1) / RECOVER_WIDTH;
  endfunction

endpackage

// File: rtl/amt_recover_lane_mask.sv
// Valid-lane mask for one recovery group starting at base.
// Also used by the RMT checkpoint logic.
module amt_recover_lane_mask
  import amt_recovery_pkg::*;
#(
  parameter int SIZE_RMT     = 34,
  parameter int SIZE_RMT_LOG = 6
) (
  input  logic [SIZE_RMT_LOG-1:0]  base,
  output logic [RECOVER_WIDTH-1:0] laneMask
);

  // Lane k is valid when base+k lands inside the table; extra bit avoids wrap
  always_comb begin
    laneMask = '0;
    for (int k = 0; k < RECOVER_WIDTH; k++) begin
      laneMask[k] = (({1'b0, base} + (SIZE_RMT_LOG + 1)'(k)) < (SIZE_RMT_LOG + 1)'(SIZE_RMT));
    end
  end

endmodule

// File: rtl/amt_recovery_sequencer.sv
// Walks the AMT four entries per cycle and rewrites the RMT after a recovery request.
// Optional feature macro: AMT_RECOVER_PIPE_EN (one register stage between AMT read and RMT write,
// plus one drain cycle before done).
module amt_recovery_sequencer
  import amt_recovery_pkg::*;
#(
  parameter int SIZE_RMT          = 34,
  parameter int SIZE_RMT_LOG      = 6,
  parameter int SIZE_PHYSICAL_LOG = 7
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  recoverFlag_i,
  output logic [SIZE_RMT_LOG-1:0]               amtAddr0_o,
  output logic [SIZE_RMT_LOG-1:0]               amtAddr1_o,
  output logic [SIZE_RMT_LOG-1:0]               amtAddr2_o,
  output logic [SIZE_RMT_LOG-1:0]               amtAddr3_o,
  input  logic [SIZE_PHYSICAL_LOG-1:0]          amtData0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]          amtData1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]          amtData2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]          amtData3_i,
  output logic [3:0]                            rmtWe_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket0_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket1_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket2_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket3_o,
  output logic                                  commitStall_o,
  output logic                                  recoveryBusy_o,
  output logic                                  recoverDone_o
);

  localparam int PKT_W    = SIZE_RMT_LOG + SIZE_PHYSICAL_LOG;
  localparam int IDX_LSB  = pktIndexLsb(SIZE_PHYSICAL_LOG);
  localparam int GROUPS   = groupCount(SIZE_RMT);
  localparam logic [SIZE_RMT_LOG-1:0] LAST_BASE = SIZE_RMT_LOG'(RECOVER_WIDTH * (GROUPS - 1));
`ifdef AMT_RECOVER_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  recoverState_t                state;
  logic [SIZE_RMT_LOG-1:0]      base;
  logic                         busyQ;
  logic                         doneQ;
  logic [RECOVER_WIDTH-1:0]     laneMask;
  logic [RECOVER_WIDTH-1:0]     walkMask;
  logic [SIZE_RMT_LOG-1:0]      laneAddr [RECOVER_WIDTH];
  logic [SIZE_PHYSICAL_LOG-1:0] amtData  [RECOVER_WIDTH];
  logic [PKT_W-1:0]             packet   [RECOVER_WIDTH];
  logic                         lastGroup;

  amt_recover_lane_mask #(
    .SIZE_RMT     (SIZE_RMT),
    .SIZE_RMT_LOG (SIZE_RMT_LOG)
  ) u_lane_mask (
    .base     (base),
    .laneMask (laneMask)
  );

  assign amtData[0] = amtData0_i;
  assign amtData[1] = amtData1_i;
  assign amtData[2] = amtData2_i;
  assign amtData[3] = amtData3_i;

  // Comparing against the final base means base never steps past the table
  assign lastGroup = (base == LAST_BASE);
  assign walkMask  = (state == WALK) ? laneMask : '0;

  // AMT read addresses; masked or idle lanes read entry 0
  always_comb begin
    for (int k = 0; k < RECOVER_WIDTH; k++) begin
      laneAddr[k] = walkMask[k] ? (base + SIZE_RMT_LOG'(k)) : '0;
    end
  end

`ifdef AMT_RECOVER_PIPE_EN
  logic [RECOVER_WIDTH-1:0]     pipeWe;
  logic [SIZE_RMT_LOG-1:0]      pipeIdx  [RECOVER_WIDTH];
  logic [SIZE_PHYSICAL_LOG-1:0] pipeData [RECOVER_WIDTH];

  // Pipeline register between AMT read and RMT write; a restart flushes it
  always_ff @(posedge clk) begin
    if (reset || recoverFlag_i) begin
      pipeWe <= '0;
    end else begin
      pipeWe <= walkMask;
    end
    for (int k = 0; k < RECOVER_WIDTH; k++) begin
      pipeIdx[k]  <= laneAddr[k];
      pipeData[k] <= amtData[k];
    end
  end

  // RMT packets from the pipeline register
  always_comb begin
    for (int k = 0; k < RECOVER_WIDTH; k++) begin
      packet[k] = '0;
      if (pipeWe[k]) begin
        packet[k][PKT_TAG_LSB +: SIZE_PHYSICAL_LOG] = pipeData[k];
        packet[k][IDX_LSB +: SIZE_RMT_LOG]          = pipeIdx[k];
      end
    end
  end

  assign rmtWe_o = pipeWe;
`else
  // RMT packets passed straight through from the AMT read
  always_comb begin
    for (int k = 0; k < RECOVER_WIDTH; k++) begin
      packet[k] = '0;
      if (walkMask[k]) begin
        packet[k][PKT_TAG_LSB +: SIZE_PHYSICAL_LOG] = amtData[k];
        packet[k][IDX_LSB +: SIZE_RMT_LOG]          = laneAddr[k];
      end
    end
  end

  assign rmtWe_o = walkMask;
`endif

  // Walk FSM with registered busy/done; any request restarts from base 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base  <= '0;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (recoverFlag_i) begin
        state <= WALK;
        base  <= '0;
        busyQ <= 1'b1;
      end else begin
        case (state)
          WALK: begin
            if (lastGroup) begin
              state <= DONE;
              // Pipelined build spends DONE draining the last group
              busyQ <= PIPE_EN;
              doneQ <= !PIPE_EN;
            end else begin
              base  <= base + SIZE_RMT_LOG'(RECOVER_WIDTH);
              busyQ <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busyQ <= 1'b0;
            doneQ <= PIPE_EN;
          end
          default: begin
            state <= IDLE;
            busyQ <= 1'b0;
          end
        endcase
      end
    end
  end

  assign amtAddr0_o     = laneAddr[0];
  assign amtAddr1_o     = laneAddr[1];
  assign amtAddr2_o     = laneAddr[2];
  assign amtAddr3_o     = laneAddr[3];
  assign rmtPacket0_o   = packet[0];
  assign rmtPacket1_o   = packet[1];
  assign rmtPacket2_o   = packet[2];
  assign rmtPacket3_o   = packet[3];
  assign commitStall_o  = recoverFlag_i | (state != IDLE);
  assign recoveryBusy_o = busyQ;
  assign recoverDone_o  = doneQ;

endmodule

// File: tb/tb_amt_recovery_sequencer.sv
// Bench for amt_recovery_sequencer (default build, AMT_RECOVER_PIPE_EN undefined).
module tb_amt_recovery_sequencer;

  localparam int SIZE = 34;
  localparam int LOGW = 6;
  localparam int PHYW = 7;
  localparam int NGRP = (SIZE + 3) / 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            recoverFlag;
  logic [LOGW-1:0] amtAddr [4];
  logic [PHYW-1:0] amtData [4];
  logic [3:0]      rmtWe;
  logic [LOGW+PHYW-1:0] rmtPacket [4];
  logic            commitStall;
  logic            recoveryBusy;
  logic            recoverDone;

  logic [PHYW-1:0] amt [64];

  int errors = 0;
  int checks = 0;
  // Cycles since the last accepted request: 0 idle, 1..NGRP walking, NGRP+1 done
  int since  = 0;

  always #5 clk = ~clk;

  assign amtData[0] = amt[amtAddr[0]];
  assign amtData[1] = amt[amtAddr[1]];
  assign amtData[2] = amt[amtAddr[2]];
  assign amtData[3] = amt[amtAddr[3]];

  amt_recovery_sequencer #(
    .SIZE_RMT          (SIZE),
    .SIZE_RMT_LOG      (LOGW),
    .SIZE_PHYSICAL_LOG (PHYW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .recoverFlag_i  (recoverFlag),
    .amtAddr0_o     (amtAddr[0]),
    .amtAddr1_o     (amtAddr[1]),
    .amtAddr2_o     (amtAddr[2]),
    .amtAddr3_o     (amtAddr[3]),
    .amtData0_i     (amtData[0]),
    .amtData1_i     (amtData[1]),
    .amtData2_i     (amtData[2]),
    .amtData3_i     (amtData[3]),
    .rmtWe_o        (rmtWe),
    .rmtPacket0_o   (rmtPacket[0]),
    .rmtPacket1_o   (rmtPacket[1]),
    .rmtPacket2_o   (rmtPacket[2]),
    .rmtPacket3_o   (rmtPacket[3]),
    .commitStall_o  (commitStall),
    .recoveryBusy_o (recoveryBusy),
    .recoverDone_o  (recoverDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (since=%0d)", tag, obs, exp, since);
    end
  endtask

  // Expected outputs from the walk position: group n-1 covers entries 4(n-1)..4(n-1)+3
  task automatic checkAll(input bit flag);
    bit   walking;
    int   idx;
    logic [3:0] expWe;
    walking = (since >= 1) && (since <= NGRP);
    expWe   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = 4 * (since - 1) + k;
      if (walking && idx < SIZE) begin
        expWe[k] = 1'b1;
        chk($sformatf("addr%0d", k), 32'(amtAddr[k]), 32'(idx));
        chk($sformatf("pkt%0d", k), 32'(rmtPacket[k]), 32'(idx * (1 << PHYW) + amt[idx]));
      end else begin
        chk($sformatf("addr%0d", k), 32'(amtAddr[k]), 32'd0);
        chk($sformatf("pkt%0d", k), 32'(rmtPacket[k]), 32'd0);
      end
    end
    chk("we", 32'(rmtWe), 32'(expWe));
    chk("busy", 32'(recoveryBusy), 32'(walking));
    chk("done", 32'(recoverDone), 32'(since == NGRP + 1));
    chk("stall", 32'(commitStall), 32'(flag || since != 0));
  endtask

  // Drive one cycle, check it, then advance the reference position at the edge
  task automatic cycle(input bit f, input bit r);
    recoverFlag = f;
    reset       = r;
    #1;
    checkAll(f);
    @(posedge clk);
    if (r) since = 0;
    else if (f) since = 1;
    else if (since >= 1 && since <= NGRP) since++;
    else since = 0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) amt[i] = PHYW'(i + 40);
    reset       = 1'b1;
    recoverFlag = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 0);

    // Basic walk with AMT entry i = i+40
    cycle(1, 0);
    for (int i = 0; i < NGRP + 3; i++) cycle(0, 0);

    // Restart once base reaches 16
    cycle(1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 0; i < NGRP + 3; i++) cycle(0, 0);

    // Reset at base 20
    cycle(1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0);
    cycle(0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0);

    // Randomized requests, resets and AMT contents
    for (int i = 0; i < 50; i++) amt[i] = PHYW'($urandom);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) amt[$urandom_range(0, SIZE - 1)] = PHYW'($urandom);
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i < NGRP + 3; i++) cycle(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amt_recovery_sequencer.md
# amt_recovery_sequencer

Sequences architectural-state recovery after an exception or branch mispredict. On a recovery request it walks the Architectural Map Table in groups of four logical registers: it drives the AMT read addresses, forwards each read mapping to one of the Rename Map Table's four write ports, and holds off commit until the walk completes. It sits between the Active List (which raises the request), the AMT read ports and the RMT write ports.

## Interface
- SIZE_RMT, 34, number of logical registers (AMT/RMT entries)
- SIZE_RMT_LOG, 6, logical register index width
- SIZE_PHYSICAL_LOG, 7, physical register tag width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- recoverFlag_i  in  1  recovery request from Active List; single-cycle pulse
- amtAddr0_o..amtAddr3_o  out  SIZE_RMT_LOG  AMT read addresses, group base + k
- amtData0_i..amtData3_i  in  SIZE_PHYSICAL_LOG  AMT read data, combinational from the addresses
- rmtWe_o  out  4  per-port RMT write enable
- rmtPacket0_o..rmtPacket3_o  out  SIZE_RMT_LOG+SIZE_PHYSICAL_LOG  {logical index, physical tag}
- commitStall_o  out  1  blocks Active List commit and AMT writes
- recoveryBusy_o  out  1  walk in progress; rename must stall
- recoverDone_o  out  1  one-cycle pulse when the RMT is fully restored

## Operation
- FSM states:
  - IDLE: no walk in progress.
  - WALK: writes one group of four entries per cycle.
  - DONE: one cycle; pulses recoverDone_o.
- Transitions:
  - IDLE -> WALK when recoverFlag_i = 1; base is set to 0.
  - WALK -> WALK with base += 4 while base + 4 < SIZE_RMT.
  - WALK -> DONE after the last group.
  - DONE -> IDLE.
- Group count G = ceil(SIZE_RMT/4). With the defaults G = 9 and the final base is 32.
- Base counter:
  - Width is SIZE_RMT_LOG; it always advances by exactly 4.
  - Lane index base+k is computed in SIZE_RMT_LOG+1 bits.
  - Lane k is written only if base+k < SIZE_RMT. The last group is partial: mask 4'b0011 for SIZE_RMT = 34.
  - A masked lane drives address 0 and packet 0, with its enable low.
- rmtPacketk_o = {base+k truncated to SIZE_RMT_LOG, amtDatak_i}.
- commitStall_o = recoverFlag_i | (state != IDLE). It is combinational, so commit is blocked in the request cycle.
- A recoverFlag_i in WALK or DONE restarts the walk: base returns to 0, state goes to WALK, and no recoverDone_o pulse is issued for the aborted walk.
- Reset mid-walk: state goes to IDLE and all outputs return to reset values on the next edge. No done pulse is issued.
- In IDLE, amtAddrk_o = 0 and rmtWe_o = 0.

## Timing
- Reset values: state IDLE, base 0, rmtWe_o 0, all packets 0, commitStall_o = recoverFlag_i, recoveryBusy_o 0, recoverDone_o 0.
- recoverFlag_i is sampled at edge T.
  - Group 0 addresses and writes appear in cycle T+1.
  - Group g appears in cycle T+1+g.
  - recoverDone_o pulses in cycle T+G+1.
  - recoveryBusy_o is high for cycles T+1..T+G.
  - Defaults: done arrives 10 cycles after the request.
- RMT writes take effect at the clock edge that ends their cycle. Rename may resume in the cycle after recoverDone_o.

## Configuration
- AMT_RECOVER_PIPE_EN defined:
  - amtData and lane index/mask are registered one stage before driving the RMT.
  - rmtWe_o and rmtPacket lag amtAddr by one cycle.
  - An extra drain cycle is added; done pulses at T+G+2 and busy stays high through T+G+1.
  - A restart flushes the pipeline register: its enables are cleared.
- Undefined: combinational pass-through as described above.

## Structure
- Shared package amt_recovery_pkg holds:
  - the FSM state enum (IDLE, WALK, DONE);
  - RECOVER_WIDTH = 4;
  - the group count function ceil(SIZE_RMT/4);
  - the packet field offset constants, which are shared with the AMT and RMT.
- Sub-module amt_recover_lane_mask computes the 4-bit valid mask from base and SIZE_RMT. It is reused by the RMT checkpoint logic.

## Test plan
- **Basic walk.** Reset, then AMT entry i = i+40; pulse recoverFlag_i. Expect 9 groups in cycles T+1..T+9 with packets {i, i+40}, rmtWe_o = 4'b1111 for groups 0-7 and 4'b0011 for base 32, and a done pulse at T+10.
- **Restart mid-walk.** Second recoverFlag_i while base = 16. Expect the next cycle to have base 0, no done pulse for the first walk, and done 10 cycles after the second pulse.
- **Commit blocking.** Assert recoverFlag_i while the Active List commits. Expect commitStall_o = 1 in the same cycle and through T+10; it is 0 at T+11.
- **Reset mid-walk.** Assert reset at base = 20. Expect IDLE the next cycle, rmtWe_o = 0, busy 0, and no done pulse.
- **Pipelined build.** With AMT_RECOVER_PIPE_EN defined and the same stimulus as the basic walk, expect identical packet values one cycle later and done at T+11.
- **Odd parameter.** SIZE_RMT = 32, SIZE_RMT_LOG = 5. Expect 8 full groups, base wrapping 28 -> DONE without overflow, and done at T+9.
